fsm_transition_engine: RTL

Registered, parametrised state-transition engine for table-driven FSMs. Each cycle it evaluates up to INPUTS candidate transitions, each with its own enable, source-state match, priority and target, and commits the winner to the state register. Beyond plain priority selection it adds source-state qualification, a per-entry dwell counter with timeout transition, a hold/freeze control, illegal-target trapping and transition reporting. It sits under protocol and sequencer FSMs that load their transition table from configuration instead of hard-coded case statements.

---
 rtl/fsm_pkg.sv | 23 ++
 rtl/fsm_prio_select.sv | 36 +++
 rtl/fsm_transition_engine.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
// Shared types and width helpers for the table-driven transition engine.
// Candidate fields use fixed maximum widths and are zero-extended from narrower parameterisations.
package fsm_pkg;

  localparam int unsigned MAX_STW = 16;
  localparam int unsigned MAX_PRW = 16;

  typedef logic [MAX_STW-1:0] state_t;
  typedef logic [MAX_PRW-1:0] prio_t;

  typedef struct packed {
    logic   en;
    logic   any;
    state_t src;
    prio_t  prio;
    state_t next;
  } cand_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fsm_prio_select.sv
// Combinational winner selection: highest priority among matching candidates, ties to lowest index.
module fsm_prio_select
  import fsm_pkg::*;
#(
  parameter int unsigned INPUTS = 8,
  parameter int unsigned IDXW   = 3
) (
  input  cand_t            i_cand [INPUTS],
  input  state_t           i_state,
  output logic             o_match_c,
  output logic [IDXW-1:0]  o_idx_c,
  output state_t           o_next_c
);

  logic  w_hit;
  prio_t w_best_prio;

  always_comb begin
    o_match_c   = 1'b0;
    o_idx_c     = '0;
    o_next_c    = '0;
    w_best_prio = '0;
    w_hit       = 1'b0;
    for (int i = 0; i < int'(INPUTS); i++) begin
      w_hit = i_cand[i].en & (i_cand[i].any | (i_cand[i].src == i_state));
      // Strict greater-than keeps the earlier (lower) index on ties.
      if (w_hit && (!o_match_c || (i_cand[i].prio > w_best_prio))) begin
        o_match_c   = 1'b1;
        o_idx_c     = IDXW'(i);
        o_next_c    = i_cand[i].next;
        w_best_prio = i_cand[i].prio;
      end
    end
  end

endmodule

// File: rtl/fsm_transition_engine.sv
// Registered state-transition engine: candidate selection, dwell/timeout, hold and illegal-target trap.
module fsm_transition_engine
  import fsm_pkg::*;
#(
  parameter int unsigned INPUTS      = 8,
  parameter int unsigned STATES      = 16,
  parameter int unsigned RESET_STATE = 0,
  parameter int unsigned DWELL_W     = 16,
  localparam int unsigned STWIDTH    = $clog2(STATES),
  localparam int unsigned PRWIDTH    = clog2_min1(INPUTS),
  localparam int unsigned IDXW       = clog2_min1(INPUTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INPUTS-1:0]           ine,
  input  logic [INPUTS-1:0]           src_any,
  input  logic [INPUTS*STWIDTH-1:0]   src_state,
  input  logic [INPUTS*PRWIDTH-1:0]   prio,
  input  logic [INPUTS*STWIDTH-1:0]   next_state,
  input  logic                        hold,
  input  logic [DWELL_W-1:0]          tmo_limit,
  input  logic [STWIDTH-1:0]          tmo_state,
  output logic [STWIDTH-1:0]          state,
  output logic [STWIDTH-1:0]          state_prev,
  output logic                        entered,
  output logic [DWELL_W-1:0]          dwell,
  output logic [IDXW-1:0]             trans_idx,
  output logic                        trans_tmo,
  output logic                        err
);

  cand_t              w_cand [INPUTS];
  logic               w_match;
  logic [IDXW-1:0]    w_sel_idx;
  state_t             w_sel_next;
  state_t             w_target;
  logic               w_tmo_fire;
  logic               w_commit;
  logic               w_illegal;

  logic [STWIDTH-1:0] r_state, r_prev, w_nxt_state, w_nxt_prev;
  logic [DWELL_W-1:0] r_dwell, w_nxt_dwell;
  logic [IDXW-1:0]    r_idx, w_nxt_idx;
  logic               r_entered, r_tmo, r_err;
  logic               w_nxt_entered, w_nxt_tmo, w_nxt_err;

  // Unpack the flattened candidate table.
  always_comb begin
    for (int i = 0; i < int'(INPUTS); i++) begin
      w_cand[i].en   = ine[i];
      w_cand[i].any  = src_any[i];
      w_cand[i].src  = state_t'(src_state[i*STWIDTH +: STWIDTH]);
      w_cand[i].prio = prio_t'(prio[i*PRWIDTH +: PRWIDTH]);
      w_cand[i].next = state_t'(next_state[i*STWIDTH +: STWIDTH]);
    end
  end

  fsm_prio_select #(
    .INPUTS (INPUTS),
    .IDXW   (IDXW)
  ) u_sel (
    .i_cand    (w_cand),
    .i_state   (state_t'(r_state)),
    .o_match_c (w_match),
    .o_idx_c   (w_sel_idx),
    .o_next_c  (w_sel_next)
  );

  assign w_tmo_fire = !w_match && (tmo_limit != '0) && (r_dwell == tmo_limit);
  assign w_commit   = !hold && (w_match || w_tmo_fire);
  assign w_target   = w_match ? w_sel_next : state_t'(tmo_state);
  assign w_illegal  = 32'(w_target) >= STATES;

  // Next-state logic for all registered outputs.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_prev    = r_prev;
    w_nxt_dwell   = r_dwell;
    w_nxt_idx     = r_idx;
    w_nxt_entered = 1'b0;
    w_nxt_tmo     = 1'b0;
    w_nxt_err     = 1'b0;
    if (hold) begin
      w_nxt_dwell = r_dwell;
    end else if (w_commit) begin
      w_nxt_state   = w_illegal ? STWIDTH'(RESET_STATE) : STWIDTH'(w_target);
      w_nxt_prev    = r_state;
      w_nxt_dwell   = '0;
      w_nxt_idx     = w_match ? w_sel_idx : r_idx;
      w_nxt_entered = 1'b1;
      w_nxt_tmo     = w_tmo_fire;
      w_nxt_err     = w_illegal;
    end else if (r_dwell != '1) begin
      w_nxt_dwell = r_dwell + DWELL_W'(1);
    end
  end

  // Reset counts as an entry into RESET_STATE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= STWIDTH'(RESET_STATE);
      r_prev    <= STWIDTH'(RESET_STATE);
      r_dwell   <= '0;
      r_idx     <= '0;
      r_entered <= 1'b1;
      r_tmo     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_prev    <= w_nxt_prev;
      r_dwell   <= w_nxt_dwell;
      r_idx     <= w_nxt_idx;
      r_entered <= w_nxt_entered;
      r_tmo     <= w_nxt_tmo;
      r_err     <= w_nxt_err;
    end
  end

  assign state      = r_state;
  assign state_prev = r_prev;
  assign dwell      = r_dwell;
  assign trans_idx  = r_idx;
  assign entered    = r_entered;
  assign trans_tmo  = r_tmo;
  assign err        = r_err;

endmodule
